// File: rtl/tlp_xcvr_pkg.sv
// Shared types and sizing for the CPU->FPGA chunk queue logic.
// C2F_CHUNKSIZE QWs per chunk, C2F_NUMCHUNKS chunks in the ring.
package tlp_xcvr_pkg;

  localparam int NC_NBITS   = 2;
  localparam int CQ_NBITS   = 9;
  localparam int RATE_NBITS = 16;

  localparam int C2F_NUMCHUNKS = 1 << NC_NBITS;
  localparam int C2F_CHUNKSIZE = 1 << CQ_NBITS;

  typedef logic [NC_NBITS-1:0]          C2FChunkIndex;
  typedef logic [CQ_NBITS-1:0]          C2FChunkOffset;
  typedef logic [NC_NBITS+CQ_NBITS-1:0] C2FQwAddr;

  typedef enum logic [1:0] {
    C2F_IDLE,
    C2F_READ,
    C2F_SUM,
    C2F_WAIT
  } C2FConsState;

  function automatic C2FQwAddr c2fQwAddr(input C2FChunkIndex chunk, input C2FChunkOffset offset);
    return {chunk, offset};
  endfunction

endpackage

// File: rtl/c2f_rate_limiter.sv
// Loadable down-counter pacing the consumer; go_o marks the last cycle of a throttle period.
// The load cycle itself counts as one elapsed cycle, so a period of N cycles follows a load of N.
module c2f_rate_limiter
  import tlp_xcvr_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [RATE_NBITS-1:0] loadVal_i,
  output logic                  go_o
);

  logic [RATE_NBITS-1:0] count_q;
  logic [RATE_NBITS-1:0] count_d;
  logic [RATE_NBITS-1:0] current;

  always_comb begin
    current = load_i ? loadVal_i : count_q;
    count_d = count_q;
    if (current != '0) begin
      count_d = current - RATE_NBITS'(1);
    end
  end

  assign go_o = (current <= RATE_NBITS'(1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/c2f_consumer_ctrl.sv
// Drain end of the C2F chunk queue: reads committed chunks one QW at a time and posts rdPtr write-backs.
// Define C2F_CHECKSUM_EN to build the 64-bit running checksum; otherwise checksum_out is tied to 0.
module c2f_consumer_ctrl
  import tlp_xcvr_pkg::*;
(
  input  logic                         pcieClk_in,
  input  logic                         reset_in,
  input  logic                         ptrReset_in,
  input  logic                         wrPtrValid_in,
  input  logic [NC_NBITS-1:0]          wrPtr_in,
  input  logic [RATE_NBITS-1:0]        rate_in,
  output logic [NC_NBITS+CQ_NBITS-1:0] ramAddr_out,
  output logic                         ramRdEn_out,
  input  logic [63:0]                  ramData_in,
  output logic [NC_NBITS-1:0]          rdPtr_out,
  output logic                         empty_out,
  output logic [63:0]                  checksum_out,
  output logic                         mtrValid_out,
  output logic [31:0]                  mtrData_out,
  input  logic                         mtrReady_in
);

  localparam C2FChunkOffset LAST_QW = C2FChunkOffset'(C2F_CHUNKSIZE - 1);

  C2FConsState   state_q, state_d;
  C2FChunkIndex  wrPtr_q, wrPtr_d;
  C2FChunkIndex  rdPtr_q, rdPtr_d;
  C2FChunkOffset qwIndex_q, qwIndex_d;
  logic          mtrValid_q, mtrValid_d;
  C2FChunkIndex  mtrData_q, mtrData_d;

  logic                  clearAll;
  logic                  empty;
  logic                  chunkDone;
  logic                  canStart;
  logic                  throttleGo;
  logic [RATE_NBITS-1:0] throttleVal;

  assign clearAll    = reset_in | ptrReset_in;
  assign empty       = (rdPtr_q == wrPtr_q);
  assign throttleVal = (rate_in != '0) ? rate_in - RATE_NBITS'(1) : '0;

  c2f_rate_limiter u_throttle (
    .clk_i     (pcieClk_in),
    .reset_i   (clearAll),
    .load_i    (state_q == C2F_SUM),
    .loadVal_i (throttleVal),
    .go_o      (throttleGo)
  );

  always_comb begin
    wrPtr_d    = wrPtrValid_in ? wrPtr_in : wrPtr_q;
    rdPtr_d    = rdPtr_q;
    qwIndex_d  = qwIndex_q;
    mtrValid_d = mtrValid_q;
    mtrData_d  = mtrData_q;
    chunkDone  = 1'b0;
    if (state_q == C2F_SUM) begin
      if (qwIndex_q == LAST_QW) begin
        qwIndex_d = '0;
        rdPtr_d   = rdPtr_q + C2FChunkIndex'(1);
        chunkDone = 1'b1;
      end else begin
        qwIndex_d = qwIndex_q + C2FChunkOffset'(1);
      end
    end
    // A new advance overrides an acceptance in the same cycle so the newest pointer stays pending.
    if (mtrValid_q && mtrReady_in) begin
      mtrValid_d = 1'b0;
    end
    if (chunkDone) begin
      mtrValid_d = 1'b1;
      mtrData_d  = rdPtr_d;
    end
  end

  // Leaving SUM/WAIT goes straight to READ when more data is ready, giving max(R,2) spacing.
  always_comb begin
    state_d  = state_q;
    canStart = (rdPtr_d != wrPtr_d) && (rate_in != '0);
    unique case (state_q)
      C2F_IDLE: begin
        if (!empty && (rate_in != '0)) begin
          state_d = C2F_READ;
        end
      end
      C2F_READ: state_d = C2F_SUM;
      C2F_SUM: begin
        if (throttleGo) begin
          state_d = canStart ? C2F_READ : C2F_IDLE;
        end else begin
          state_d = C2F_WAIT;
        end
      end
      C2F_WAIT: begin
        if (throttleGo) begin
          state_d = canStart ? C2F_READ : C2F_IDLE;
        end
      end
      default: state_d = C2F_IDLE;
    endcase
  end

  always_ff @(posedge pcieClk_in) begin
    if (clearAll) begin
      state_q    <= C2F_IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      qwIndex_q  <= '0;
      mtrValid_q <= 1'b0;
      mtrData_q  <= '0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      qwIndex_q  <= qwIndex_d;
      mtrValid_q <= mtrValid_d;
      mtrData_q  <= mtrData_d;
    end
  end

`ifdef C2F_CHECKSUM_EN
  logic [63:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == C2F_SUM) begin
      checksum_d = checksum_q + ramData_in;
    end
  end

  always_ff @(posedge pcieClk_in) begin
    if (clearAll) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum_out = checksum_q;
`else
  logic unusedRamData;
  assign unusedRamData = ^ramData_in;
  assign checksum_out  = '0;
`endif

  assign ramRdEn_out  = (state_q == C2F_READ);
  assign ramAddr_out  = c2fQwAddr(rdPtr_q, qwIndex_q);
  assign rdPtr_out    = rdPtr_q;
  assign empty_out    = empty;
  assign mtrValid_out = mtrValid_q;
  assign mtrData_out  = {{(32-NC_NBITS){1'b0}}, mtrData_q};

endmodule
